// File: rtl/lcd_pkg.sv
// Shared definitions for the ST7789 LCD pipeline: RGB565 colours, pattern
// mode encodings and the default panel geometry.
package lcd_pkg;

  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] BLACK   = 16'h0000;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] MAGENTA = 16'hF81F;

  localparam int LCD_H_ACTIVE = 240;
  localparam int LCD_V_ACTIVE = 135;

  typedef enum logic [1:0] {
    MODE_HBANDS   = 2'd0,
    MODE_VBARS    = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } pat_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } src_state_e;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = YELLOW;
      3'd2:    c = CYAN;
      3'd3:    c = GREEN;
      3'd4:    c = MAGENTA;
      3'd5:    c = RED;
      3'd6:    c = BLUE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_pixel_src_if.sv
// Pixel stream between the pattern source and the SPI serializer:
// valid/ready handshake carrying one RGB565 pixel with raster markers.
interface lcd_pixel_src_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_eof;

  modport master (
    output pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
    output pix_ready
  );
endinterface

// File: rtl/lcd_pattern_lut.sv
// Combinational test-pattern generator: maps (mode, effective x, y, bar index)
// to an RGB565 pixel. The bar index comes from a running column counter.
module lcd_pattern_lut
  import lcd_pkg::*;
#(
  parameter int BAR_ROWS = 45
) (
  input  logic [1:0]  mode_i,
  input  logic [8:0]  x_i,
  input  logic [7:0]  y_i,
  input  logic [2:0]  bar_i,
  output logic [15:0] pix_o
);
  localparam logic [8:0] ROW1 = 9'(BAR_ROWS);
  localparam logic [8:0] ROW2 = 9'(2 * BAR_ROWS);

  logic [8:0] sum;

  always_comb begin
    sum   = x_i + {1'b0, y_i};
    pix_o = BLACK;
    case (pat_mode_e'(mode_i))
      MODE_HBANDS: begin
        if ({1'b0, y_i} < ROW1)      pix_o = BLUE;
        else if ({1'b0, y_i} < ROW2) pix_o = GREEN;
        else                         pix_o = RED;
      end
      MODE_VBARS:    pix_o = bar_colour(bar_i);
      MODE_CHECKER:  pix_o = (x_i[3] ^ y_i[3]) ? WHITE : BLACK;
      MODE_GRADIENT: pix_o = {x_i[7:3], y_i[7:2], sum[8:4]};
      default:       pix_o = BLACK;
    endcase
  end
endmodule

// File: rtl/lcd_pixel_src.sv
// Frame-at-a-time RGB565 test-pattern source with registered valid/ready output.
// Define PATTERN_ANIM_EN to scroll the pattern horizontally by SCROLL_STEP per frame.
module lcd_pixel_src
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE    = LCD_H_ACTIVE,
  parameter int V_ACTIVE    = LCD_V_ACTIVE,
  parameter int BAR_ROWS    = 45,
  parameter int BAR_COLS    = 30,
  parameter int SCROLL_STEP = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [1:0]      mode,
  lcd_pixel_src_if.master pix,
  output logic            busy,
  output logic            done,
  output logic [7:0]      frame_cnt
);
  localparam logic [8:0] X_LAST   = 9'(H_ACTIVE - 1);
  localparam logic [7:0] Y_LAST   = 8'(V_ACTIVE - 1);
  localparam logic [8:0] COL_LAST = 9'(BAR_COLS - 1);

  src_state_e  state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [8:0]  x_q, x_d, xe_q, xe_d, bcnt_q, bcnt_d;
  logic [7:0]  y_q, y_d;
  logic [2:0]  bidx_q, bidx_d;
  logic        valid_q, valid_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
  logic [15:0] data_q, data_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [7:0]  fc_q, fc_d;

  logic [8:0]  line_xe, line_bcnt;
  logic [2:0]  line_bidx;
  logic [8:0]  cx, cxe, cbcnt;
  logic [7:0]  cy;
  logic [2:0]  cbidx;
  logic [1:0]  lut_mode;
  logic [15:0] lut_pix;
  logic        xfer, load;

  assign xfer = valid_q & pix.pix_ready;

`ifdef PATTERN_ANIM_EN
  // Bar position of the first column of each line tracks the scroll offset,
  // so no division is needed; assumes SCROLL_STEP <= BAR_COLS.
  logic [8:0] scroll_q, scroll_d, sbcnt_q, sbcnt_d;
  logic [2:0] sbidx_q, sbidx_d;
  logic [9:0] scroll_sum, sbcnt_sum;

  assign line_xe   = scroll_q;
  assign line_bcnt = sbcnt_q;
  assign line_bidx = sbidx_q;

  always_comb begin
    scroll_sum = {1'b0, scroll_q} + 10'(SCROLL_STEP);
    sbcnt_sum  = {1'b0, sbcnt_q} + 10'(SCROLL_STEP);
    scroll_d   = scroll_q;
    sbcnt_d    = sbcnt_q;
    sbidx_d    = sbidx_q;
    if (state_q == ST_DONE) begin
      if (scroll_sum >= 10'(H_ACTIVE)) begin
        scroll_d = 9'(scroll_sum - 10'(H_ACTIVE));
        sbcnt_d  = 9'(scroll_sum - 10'(H_ACTIVE));
        sbidx_d  = 3'd0;
      end else begin
        scroll_d = scroll_sum[8:0];
        if (sbcnt_sum >= 10'(BAR_COLS)) begin
          sbcnt_d = 9'(sbcnt_sum - 10'(BAR_COLS));
          sbidx_d = (sbidx_q == 3'd7) ? 3'd7 : sbidx_q + 3'd1;
        end else begin
          sbcnt_d = sbcnt_sum[8:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      scroll_q <= '0;
      sbcnt_q  <= '0;
      sbidx_q  <= '0;
    end else begin
      scroll_q <= scroll_d;
      sbcnt_q  <= sbcnt_d;
      sbidx_q  <= sbidx_d;
    end
  end
`else
  assign line_xe   = '0;
  assign line_bcnt = '0;
  assign line_bidx = '0;
`endif

  // Position of the pixel that will be presented after the next load.
  always_comb begin
    cx    = '0;
    cy    = '0;
    cxe   = line_xe;
    cbcnt = line_bcnt;
    cbidx = line_bidx;
    if (state_q == ST_RUN) begin
      if (x_q == X_LAST) begin
        cy = y_q + 8'd1;
      end else begin
        cx = x_q + 9'd1;
        cy = y_q;
        if (xe_q == X_LAST) begin
          cxe   = '0;
          cbcnt = '0;
          cbidx = '0;
        end else begin
          cxe = xe_q + 9'd1;
          if (bcnt_q == COL_LAST) begin
            cbcnt = '0;
            cbidx = (bidx_q == 3'd7) ? 3'd7 : bidx_q + 3'd1;
          end else begin
            cbcnt = bcnt_q + 9'd1;
            cbidx = bidx_q;
          end
        end
      end
    end
  end

  assign lut_mode = (state_q == ST_RUN) ? mode_q : mode;

  lcd_pattern_lut #(
    .BAR_ROWS (BAR_ROWS)
  ) u_lut (
    .mode_i (lut_mode),
    .x_i    (cxe),
    .y_i    (cy),
    .bar_i  (cbidx),
    .pix_o  (lut_pix)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    xe_d    = xe_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    valid_d = valid_q;
    data_d  = data_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fc_d    = fc_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mode_d  = mode;
          busy_d  = 1'b1;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          if (eof_q) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            sof_d   = 1'b0;
            eol_d   = 1'b0;
            eof_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            fc_d    = fc_q + 8'd1;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      x_d     = cx;
      y_d     = cy;
      xe_d    = cxe;
      bcnt_d  = cbcnt;
      bidx_d  = cbidx;
      valid_d = 1'b1;
      data_d  = lut_pix;
      sof_d   = (cx == '0) && (cy == '0);
      eol_d   = (cx == X_LAST);
      eof_d   = (cx == X_LAST) && (cy == Y_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      xe_q    <= '0;
      bcnt_q  <= '0;
      bidx_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xe_q    <= xe_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fc_q    <= fc_d;
    end
  end

  assign pix.pix_valid = valid_q;
  assign pix.pix_data  = data_q;
  assign pix.pix_sof   = sof_q;
  assign pix.pix_eol   = eol_q;
  assign pix.pix_eof   = eof_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign frame_cnt     = fc_q;
endmodule
